// File: rtl/w_sched_ctrl.sv
// w_sched_ctrl: SHA-256 message-schedule sequencer. Loads a 16-word block into a
// 64-entry W file, steps the schedule datapath through 64 rounds and streams W_t out.
module w_sched_ctrl #(
    parameter int ROUNDS      = 64,
    parameter int BLOCK_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [5:0]  sch_round,
    input  logic [5:0]  sch_addr_a,
    input  logic [5:0]  sch_addr_b,
    input  logic [5:0]  sch_addr_c,
    input  logic [5:0]  sch_addr_d,
    output logic [31:0] sch_a,
    output logic [31:0] sch_b,
    output logic [31:0] sch_c,
    output logic [31:0] sch_d,
    input  logic [31:0] sch_msg,
    output logic [31:0] w_out,
    output logic [5:0]  w_idx,
    output logic        w_valid,
    input  logic        w_ready,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

    localparam logic [5:0] LAST_IN    = 6'(BLOCK_WORDS - 1);
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    state_t      state, state_nx;
    logic [5:0]  cnt, cnt_nx;
    logic [31:0] w_mem [ROUNDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Handshake writes commit even when flush is asserted in the same cycle.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            w_mem[cnt] <= in_word;
        else if (w_valid && w_ready)
            w_mem[cnt] <= sch_msg;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        in_ready = 1'b0;
        w_valid  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    cnt_nx   = '0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_nx   = (cnt == LAST_IN) ? '0 : cnt + 6'd1;
                    state_nx = (cnt == LAST_IN) ? EXPAND : LOAD;
                end
            end
            EXPAND: begin
                w_valid = 1'b1;
                if (w_ready) begin
                    cnt_nx   = cnt + 6'd1;
                    state_nx = (cnt == LAST_ROUND) ? DONE : EXPAND;
                end
            end
            default: begin
                done     = 1'b1;
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end
    end

    assign busy      = (state != IDLE);
    assign sch_round = (state == EXPAND) ? cnt : '0;
    assign w_idx     = sch_round;
    assign w_out     = sch_msg;
    assign sch_a     = w_mem[sch_addr_a];
    assign sch_b     = w_mem[sch_addr_b];
    assign sch_c     = w_mem[sch_addr_c];
    assign sch_d     = w_mem[sch_addr_d];
endmodule

// File: tb/tb_w_sched_ctrl.sv
// tb_w_sched_ctrl: random-stimulus bench for w_sched_ctrl; the bench also plays the
// schedule datapath and compares every streamed W_t against a plain-arithmetic model.
module tb_w_sched_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, flush, in_valid, in_ready, w_valid, w_ready, busy, done;
    logic [31:0] in_word, sch_a, sch_b, sch_c, sch_d, sch_msg, w_out;
    logic [5:0]  sch_round, sch_addr_a, sch_addr_b, sch_addr_c, sch_addr_d, w_idx;
    logic [31:0] msg   [16];
    logic [31:0] exp_w [64];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    w_sched_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .sch_round(sch_round),
        .sch_addr_a(sch_addr_a), .sch_addr_b(sch_addr_b),
        .sch_addr_c(sch_addr_c), .sch_addr_d(sch_addr_d),
        .sch_a(sch_a), .sch_b(sch_b), .sch_c(sch_c), .sch_d(sch_d),
        .sch_msg(sch_msg), .w_out(w_out), .w_idx(w_idx),
        .w_valid(w_valid), .w_ready(w_ready), .busy(busy), .done(done)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Stand-in schedule datapath: passes loaded words through for t<16.
    always_comb begin
        sch_addr_a = sch_round - 6'd2;
        sch_addr_b = sch_round - 6'd7;
        sch_addr_c = sch_round - 6'd15;
        sch_addr_d = (sch_round < 6'd16) ? sch_round : sch_round - 6'd16;
        sch_msg    = (sch_round < 6'd16) ? sch_d : sig1(sch_a) + sch_b + sig0(sch_c) + sch_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void build_model();
        for (int t = 0; t < 64; t++)
            if (t < 16) exp_w[t] = msg[t];
            else exp_w[t] = sig1(exp_w[t-2]) + exp_w[t-7] + sig0(exp_w[t-15]) + exp_w[t-16];
    endfunction

    task automatic set_abc();
        foreach (msg[i]) msg[i] = '0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    task automatic set_rand();
        foreach (msg[i]) msg[i] = $urandom;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_w_valid"}, w_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sch_round"}, sch_round, 0);
        check({tag, "_w_idx"}, w_idx, 0);
    endtask

    task automatic run_block(input int gap, input int rdy_pct, input bit abc,
                             input bit poke, input int flush_at, input int rst_at);
        int cyc = 0;
        int k = 0;
        int t = 0;
        int gc = gap;
        int phase = 1;
        bit stalled = 1'b0;
        logic [31:0] held_w = '0;
        logic [5:0]  held_i = '0;
        build_model();
        @(negedge clk);
        start = 1'b1;
        while (phase != 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (phase == 1) begin
                check("load_in_ready", in_ready, 1);
                check("load_w_valid", w_valid, 0);
                if (k == rst_at) begin
                    in_valid = 1'b0;
                    #2 rst = 1'b1;
                    #1 check_idle_outputs("async_rst");
                    #1 rst = 1'b0;
                    phase = 0;
                end else begin
                    in_valid = (gc == 0);
                    in_word  = msg[k];
                    if (in_valid) begin k++; gc = gap; end else gc--;
                    if (k == 16) phase = 2;
                end
            end else if (phase == 2) begin
                in_valid = 1'b0;
                check("exp_w_valid", w_valid, 1);
                check("exp_w_idx", w_idx, t);
                check("exp_w_out", w_out, exp_w[t]);
                check("exp_done_early", done, 0);
                if (stalled) begin
                    check("stall_w_out", w_out, held_w);
                    check("stall_w_idx", w_idx, held_i);
                end
                if (abc && t == 16) check("abc_w16", w_out, 32'h61626380);
                if (abc && t == 63) check("abc_w63", w_out, 32'h12b1edeb);
                if (poke) start = (t == 20);
                w_ready = ($urandom_range(99) < rdy_pct);
                if (t == flush_at) begin
                    flush = 1'b1;
                    @(negedge clk);
                    flush   = 1'b0;
                    w_ready = 1'b0;
                    check_idle_outputs("flush");
                    phase = 0;
                end else begin
                    stalled = !w_ready;
                    held_w  = w_out;
                    held_i  = w_idx;
                    if (w_ready) t++;
                    if (t == 64) phase = 3;
                end
            end else begin
                w_ready = 1'b0;
                check("done_pulse", done, 1);
                check("done_w_valid", w_valid, 0);
                if (gap == 0 && rdy_pct == 100) check("done_cycle", cyc, 81);
                repeat (3) begin
                    @(negedge clk);
                    check("done_once", done, 0);
                    check("idle_busy", busy, 0);
                end
                phase = 0;
            end
        end
        if (phase != 0) check("timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = '0; w_ready = 1'b0;
        #1 check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        // flush beats start in IDLE
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_wins_busy", busy, 0);
        set_abc();  run_block(0, 100, 1'b1, 1'b0, -1, -1);
        set_abc();  run_block(0, 50,  1'b1, 1'b0, -1, -1);
        set_rand(); run_block(3, 100, 1'b0, 1'b0, -1, -1);
        set_abc();  run_block(0, 100, 1'b1, 1'b0, 30, -1);
        set_abc();  run_block(0, 100, 1'b1, 1'b0, -1, -1);
        set_rand(); run_block(0, 100, 1'b0, 1'b0, -1, 7);
        set_rand(); run_block(0, 100, 1'b0, 1'b0, -1, -1);
        set_rand(); run_block(0, 70,  1'b0, 1'b1, -1, -1);
        for (int i = 0; i < 4; i++) begin
            set_rand();
            run_block(int'($urandom_range(2)), int'($urandom_range(90, 30)), 1'b0, 1'b0, -1, -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
